// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and FSM states for the load/store unit
// Purpose: RV32I load/store funct3 codes, the LSU state enumeration and a
//          helper that classifies funct3 values the unit cannot execute.
// Ports:   none (package)
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;  // LB / SB
  localparam logic [2:0] F3_H  = 3'd1;  // LH / SH
  localparam logic [2:0] F3_W  = 3'd2;  // LW / SW
  localparam logic [2:0] F3_BU = 3'd4;  // LBU
  localparam logic [2:0] F3_HU = 3'd5;  // LHU

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_RD,
    S_WR,
    S_RESP
  } lsu_state_t;

  // Stores only exist as SB/SH/SW; loads have no encodings 3, 6 and 7.
  function automatic logic bad_funct3(input logic we, input logic [2:0] f3);
    if (we) return (f3 > F3_W);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core-side request/response bus of the load/store unit
// Purpose: bundles the request handshake and the completion response.
// Signals: req_valid/req_ready handshake, req_we (1 = store), funct3,
//          addr (byte address), wdata (right-aligned store data),
//          resp_valid (one-cycle completion), rdata (load result), err.
// Modports: master = core, slave = load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req_valid, req_we, funct3, addr, wdata,
    input  req_ready, resp_valid, rdata, err
  );

  modport slave (
    input  req_valid, req_we, funct3, addr, wdata,
    output req_ready, resp_valid, rdata, err
  );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - load data lane selection and sign/zero extension
// Purpose: combinationally picks the byte/halfword/word of a memory word
//          addressed by the low address bits (little-endian) and extends it.
// Ports:   funct3 (load width/sign code), byte_off (addr[1:0]),
//          word (raw memory word), data (formatted load result).
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{byte_off, 3'b000} +: 8];
    // Halfwords only honour addr[1]; an odd offset is either trapped upstream
    // or deliberately ignored.
    lane_h = byte_off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_BU:   data = {24'd0, lane_b};
      F3_HU:   data = {16'd0, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit in front of a word memory
// Purpose: executes LB/LH/LW/LBU/LHU/SB/SH/SW against a 32-bit word memory;
//          sub-word stores use a read-modify-write sequence.
// Ports:   clk, rst (synchronous, active-high); bus (load_store_unit_if.slave);
//          mem_read, mem_write, mem_addr[ADDR_W-1:0], mem_wdata (to memory);
//          mem_rdata (combinational read data, same cycle as mem_read).
// Config:  define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word
//          accesses; otherwise the unaligned low address bits are ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t         state, state_nxt;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        merge_q;
  logic [31:0]        rdata_q;
  logic               fault_q;
  logic               fault_in;
  logic               misalign;
  logic               handshake;
  logic [31:0]        ld_data;
  logic [31:0]        merged;

  assign handshake = (state == S_IDLE) && bus.req_valid;

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0] = 01 covers LH/LHU/SH, 10 covers LW/SW.
    misalign = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
               ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    fault_in = bad_funct3(bus.req_we, bus.funct3) || misalign;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (handshake) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.funct3;
        addr_q  <= bus.addr[ADDR_W+1:0];
        wdata_q <= bus.wdata;
        fault_q <= fault_in;
      end
      if (state == S_LD) rdata_q <= ld_data;
      if (state == S_RD) merge_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.err        = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (fault_in)               state_nxt = S_RESP;
          else if (!bus.req_we)       state_nxt = S_LD;
          else if (bus.funct3 == F3_W) state_nxt = S_WR;
          else                        state_nxt = S_RD;
        end
      end
      S_LD: begin
        mem_read  = 1'b1;
        state_nxt = S_RESP;
      end
      S_RD: begin
        mem_read  = 1'b1;
        state_nxt = S_WR;
      end
      S_WR: begin
        mem_write = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.err        = fault_q;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Store word: SW replaces everything, SB/SH patch lanes of the word read in RD.
  always_comb begin
    merged = merge_q;
    case (f3_q[1:0])
      2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  lsu_load_align u_align (
    .funct3   (f3_q),
    .byte_off (addr_q[1:0]),
    .word     (mem_rdata),
    .data     (ld_data)
  );

  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign mem_wdata = merged;
  assign bus.rdata = rdata_q;

  // we_q only steers the FSM at handshake time; kept for completeness of the latched request.
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read, mem_write;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];
  logic [31:0] model_rdata = 32'd0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  exp_t sb[$];

  load_store_unit_if bus();

  load_store_unit #(.ADDR_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lo);
    logic [31:0] sh;
    logic [31:0] hw;
    sh = w >> (lo * 8);
    hw = lo[1] ? (w >> 16) : w;
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{hw[15]}}, hw[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, hw[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_store(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    if (f3 == 3'd0) r[lo*8 +: 8] = wd[7:0];
    else if (f3 == 3'd1) begin
      if (lo[1]) r[31:16] = wd[15:0];
      else       r[15:0]  = wd[15:0];
    end else r = wd;
    return r;
  endfunction

  // Drives one request through the handshake and pushes the model's expectation.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic flt;
    int   idx;
    idx = int'(a[8:2]);
    flt = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) flt = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) flt = 1'b1;
`endif
    if (flt)              e.lat = 1;
    else if (!we)         e.lat = 2;
    else if (f3 == 3'd2)  e.lat = 2;
    else                  e.lat = 3;
    if (!flt) begin
      if (!we) model_rdata = exp_load(ref_mem[idx], f3, a[1:0]);
      else     ref_mem[idx] = exp_store(ref_mem[idx], f3, a[1:0], wd);
    end
    e.err   = flt;
    e.rdata = model_rdata;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Observes cycles 1.. after the handshake until resp_valid (bounded).
  task automatic wait_resp(output int lat, output int nrd, output int nwr, output int wcyc,
                           output logic [31:0] wd, output logic [6:0] wa);
    lat = 0; nrd = 0; nwr = 0; wcyc = 0; wd = '0; wa = '0;
    for (int c = 1; c <= 12; c++) begin
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; wcyc = c; wd = mem_wdata; wa = mem_addr; end
      if (bus.resp_valid) begin lat = c; break; end
      @(negedge clk);
    end
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    if (ok) e = sb.pop_front();
    else begin e.err = 1'bx; e.rdata = 'x; e.lat = -1; end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_checks++; if (bus.rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got rd=%b wr=%b want 0 0", mem_read, mem_write); end
    rst = 1'b0;
  endtask

  task automatic test_load_byte();
    int lat, nrd, nwr, wc; logic [31:0] wd; logic [6:0] wa; exp_t e; bit ok;
    issue(1'b0, 3'd0, 32'h15, 32'h0);
    wait_resp(lat, nrd, nwr, wc, wd, wa);
    pop_exp(e, ok);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d want 2", lat); end
    n_checks++; if (bus.rdata !== 32'hFFFFFFAA || e.rdata !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb_rdata: got %h want FFFFFFAA", bus.rdata); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL lb_err: got %b want 0", bus.err); end
    n_checks++; if (nrd !== 1 || nwr !== 0) begin n_fail++; $display("FAIL lb_mem_ops: got rd=%0d wr=%0d want 1 0", nrd, nwr); end
  endtask

  task automatic test_load_half();
    int lat, nrd, nwr, wc; logic [31:0] wd; logic [6:0] wa; exp_t e; bit ok;
    issue(1'b0, 3'd5, 32'h16, 32'h0);
    wait_resp(lat, nrd, nwr, wc, wd, wa);
    pop_exp(e, ok);
    n_checks++; if (bus.rdata !== 32'h00008899) begin n_fail++; $display("FAIL lhu_rdata: got %h want 00008899", bus.rdata); end
    n_checks++; if (lat !== 2 || !ok || bus.err !== e.err) begin n_fail++; $display("FAIL lhu_resp: got lat=%0d err=%b want lat=2 err=0", lat, bus.err); end
  endtask

  task automatic test_store_byte();
    int lat, nrd, nwr, wc; logic [31:0] wd; logic [6:0] wa; exp_t e; bit ok;
    issue(1'b1, 3'd0, 32'h17, 32'h123);
    wait_resp(lat, nrd, nwr, wc, wd, wa);
    pop_exp(e, ok);
    n_checks++; if (nrd !== 1 || nwr !== 1 || wc !== 2) begin n_fail++; $display("FAIL sb_sequence: got rd=%0d wr=%0d wr_cycle=%0d want 1 1 2", nrd, nwr, wc); end
    n_checks++; if (wd !== 32'h2399AABB || wa !== 7'd5) begin n_fail++; $display("FAIL sb_wdata: got %h@%0d want 2399AABB@5", wd, wa); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d want 3", lat); end
    n_checks++; if (bus.err !== 1'b0 || bus.rdata !== e.rdata) begin n_fail++; $display("FAIL sb_resp: got err=%b rdata=%h want err=0 rdata=%h", bus.err, bus.rdata, e.rdata); end
  endtask

  task automatic test_store_word();
    int lat, nrd, nwr, wc; logic [31:0] wd; logic [6:0] wa; exp_t e; bit ok;
    issue(1'b1, 3'd2, 32'h08, 32'hDEADBEEF);
    wait_resp(lat, nrd, nwr, wc, wd, wa);
    pop_exp(e, ok);
    n_checks++; if (nwr !== 1 || wc !== 1 || wa !== 7'd2 || wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_write: got n=%0d cyc=%0d addr=%0d data=%h want 1 1 2 DEADBEEF", nwr, wc, wa, wd); end
    n_checks++; if (nrd !== 0) begin n_fail++; $display("FAIL sw_no_read: got %0d reads want 0", nrd); end
    n_checks++; if (lat !== 2 || bus.err !== 1'b0) begin n_fail++; $display("FAIL sw_resp: got lat=%0d err=%b want 2 0", lat, bus.err); end
  endtask

  task automatic test_misalign();
    int lat, nrd, nwr, wc; logic [31:0] wd; logic [6:0] wa; exp_t e; bit ok;
    issue(1'b0, 3'd2, 32'h0A, 32'h0);
    wait_resp(lat, nrd, nwr, wc, wd, wa);
    pop_exp(e, ok);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++; if (lat !== 1 || bus.err !== 1'b1 || nrd !== 0) begin n_fail++; $display("FAIL lw_misalign_trap: got lat=%0d err=%b reads=%0d want 1 1 0", lat, bus.err, nrd); end
    n_checks++; if (bus.rdata !== e.rdata) begin n_fail++; $display("FAIL lw_misalign_rdata: got %h want %h", bus.rdata, e.rdata); end
`else
    n_checks++; if (lat !== 2 || bus.err !== 1'b0 || nrd !== 1) begin n_fail++; $display("FAIL lw_misalign_resp: got lat=%0d err=%b reads=%0d want 2 0 1", lat, bus.err, nrd); end
    n_checks++; if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_misalign_rdata: got %h want DEADBEEF", bus.rdata); end
`endif
  endtask

  task automatic test_bad_funct3();
    int lat, nrd, nwr, wc; logic [31:0] wd; logic [6:0] wa; exp_t e; bit ok;
    logic [31:0] held;
    held = bus.rdata;
    issue(1'b0, 3'd3, 32'h14, 32'h0);
    wait_resp(lat, nrd, nwr, wc, wd, wa);
    pop_exp(e, ok);
    n_checks++; if (bus.err !== 1'b1 || lat !== 1 || nrd !== 0) begin n_fail++; $display("FAIL bad_load_f3: got err=%b lat=%0d reads=%0d want 1 1 0", bus.err, lat, nrd); end
    n_checks++; if (bus.rdata !== held || held !== e.rdata) begin n_fail++; $display("FAIL bad_load_rdata: got %h want %h", bus.rdata, e.rdata); end
    issue(1'b1, 3'd4, 32'h14, 32'hFFFF);
    wait_resp(lat, nrd, nwr, wc, wd, wa);
    pop_exp(e, ok);
    n_checks++; if (bus.err !== 1'b1 || lat !== 1 || nrd !== 0 || nwr !== 0) begin n_fail++; $display("FAIL bad_store_f3: got err=%b lat=%0d rd=%0d wr=%0d want 1 1 0 0", bus.err, lat, nrd, nwr); end
  endtask

  task automatic test_reset_in_rd();
    logic [31:0] old_word;
    int wr_seen;
    exp_t e;
    old_word = ref_mem[8];
    issue(1'b1, 3'd1, 32'h22, 32'h5555);
    ref_mem[8] = old_word;
    void'(sb.pop_back());
    n_checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin n_fail++; $display("FAIL sh_rd_phase: got rd=%b wr=%b want 1 0", mem_read, mem_write); end
    rst = 1'b1;
    @(negedge clk);
    model_rdata = 32'd0;
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_rd_no_write: got %b want 0", mem_write); end
    n_checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_idle: got ready=%b resp=%b want 1 0", bus.req_ready, bus.resp_valid); end
    n_checks++; if (bus.rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rd_rdata: got %h want 0", bus.rdata); end
    rst = 1'b0;
    wr_seen = 0;
    repeat (4) begin @(negedge clk); if (mem_write || bus.resp_valid) wr_seen++; end
    n_checks++; if (wr_seen !== 0 || mem[8] !== old_word) begin n_fail++; $display("FAIL rst_rd_abandon: got activity=%0d word=%h want 0 %h", wr_seen, mem[8], old_word); end
    e.lat = 0;
  endtask

  task automatic test_back_to_back();
    logic        t_we [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  t_f3 [8] = '{3'd0, 3'd1, 3'd4, 3'd1, 3'd0, 3'd0, 3'd7, 3'd5};
    logic [31:0] t_a  [8] = '{32'h215, 32'h14, 32'h14, 32'h16, 32'h16, 32'h13, 32'h20, 32'h16};
    logic [31:0] t_wd [8] = '{32'h0, 32'h0, 32'h0, 32'h7F00ABCD, 32'h0, 32'h0, 32'h1, 32'h0};
    int lat, nrd, nwr, wc; logic [31:0] wd; logic [6:0] wa; exp_t e; bit ok;
    for (int i = 0; i < 8; i++) begin
      issue(t_we[i], t_f3[i], t_a[i], t_wd[i]);
      wait_resp(lat, nrd, nwr, wc, wd, wa);
      pop_exp(e, ok);
      n_checks++;
      if (!ok || lat !== e.lat || bus.err !== e.err || bus.rdata !== e.rdata)
        begin n_fail++; $display("FAIL b2b_%0d: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h", i, lat, bus.err, bus.rdata, e.lat, e.err, e.rdata); end
    end
    n_checks++; if (mem[5] !== ref_mem[5]) begin n_fail++; $display("FAIL b2b_mem5: got %h want %h", mem[5], ref_mem[5]); end
  endtask

  always @(negedge clk) begin
    if (mem_read && mem_write) begin
      n_checks++; n_fail++;
      $display("FAIL rd_wr_exclusive: got both enables 1 want at most one");
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = (32'h11111111 * i) ^ 32'h0F0F0F0F;
      if (i == 5) ref_mem[i] = 32'h8899AABB;
      mem[i] <= ref_mem[i];
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.funct3    = 3'd0;
    bus.addr      = 32'd0;
    bus.wdata     = 32'd0;
    test_reset();
    test_load_byte();
    test_load_half();
    test_store_byte();
    test_store_word();
    test_misalign();
    test_bad_funct3();
    test_reset_in_rd();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set the width of the memory word address.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 req_valid  input  1  SHALL mean the core presents an access.
REQ-005 req_ready  output  1  SHALL mean the unit accepts a request this cycle.
REQ-006 req_we  input  1  SHALL select the access type: 1 = store, 0 = load.
REQ-007 funct3  input  3  SHALL carry the RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 addr  input  32  SHALL be the byte address.
REQ-009 wdata  input  32  SHALL be the store data, right-aligned.
REQ-010 resp_valid  output  1  SHALL be a one-cycle completion pulse.
REQ-011 rdata  output  32  SHALL be the formatted load result, held until the next load completes.
REQ-012 err  output  1  SHALL flag a faulting access and is valid with resp_valid.
REQ-013 mem_read  output  1  SHALL be the downstream word-memory read enable.
REQ-014 mem_write  output  1  SHALL be the downstream word-memory write enable.
REQ-015 mem_addr  output  ADDR_W  SHALL equal the latched addr[ADDR_W+1:2].
REQ-016 mem_wdata  output  32  SHALL be the full word to be written.
REQ-017 mem_rdata  input  32  SHALL be the combinational read data, valid in the same cycle as mem_read.

Function
REQ-018 The FSM SHALL have the states IDLE, LD, RD, WR and RESP.
REQ-019 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-020 On a req_valid handshake the unit SHALL latch req_we, funct3, addr and wdata.
REQ-021 After a handshake the next state SHALL be: load -> LD; SW -> WR; SB/SH -> RD; fault -> RESP.
REQ-022 In LD, mem_read SHALL be 1 and rdata SHALL capture the byte/halfword/word selected by addr[1:0], sign- or zero-extended per funct3; next state RESP.
REQ-023 In RD, mem_read SHALL be 1 and the word SHALL be captured into a merge register; next state WR.
REQ-024 In WR, mem_write SHALL be 1 for exactly one cycle.
REQ-025 In WR, mem_wdata SHALL be wdata for SW, or the merge word with only the addressed byte/halfword lanes replaced; next state RESP.
REQ-026 In RESP, resp_valid SHALL be 1 for one cycle; next state IDLE.
REQ-027 Latency from handshake to resp_valid SHALL be 2 cycles for loads and SW, 3 cycles for SB/SH, and 1 cycle for faults.
REQ-028 Invalid funct3 (load 3/6/7, store >=3) SHALL give err=1, no mem_read/mem_write and rdata unchanged, regardless of configuration.
REQ-029 mem_read and mem_write SHALL never both be 1.
REQ-030 On a faulting access, rdata SHALL be unchanged.
REQ-031 Byte lane ordering SHALL be little-endian.
REQ-032 mem_addr SHALL wrap modulo 2^ADDR_W; upper address bits are ignored.

Reset
REQ-033 With rst=1 at a rising edge, the state SHALL become IDLE and resp_valid, err, rdata, mem_read and mem_write SHALL be 0.
REQ-034 A reset in RD or WR SHALL abandon the access; no mem_write SHALL occur in the cycle after the reset edge.

Configuration
REQ-035 With LSU_MISALIGN_TRAP_EN defined, LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL fault (err=1, no memory access).
REQ-036 Without LSU_MISALIGN_TRAP_EN, the unaligned low address bits SHALL be ignored (halfword uses addr[1], word ignores addr[1:0]) and misalignment SHALL never raise err.

Structure
REQ-037 Package lsu_pkg SHALL hold the funct3 encodings and the FSM state enumeration.
REQ-038 Load extraction and extension SHALL be the combinational sub-module lsu_load_align.

Verification
REQ-039 Bench SHALL check: mem word 5 = 0x8899AABB; LB addr 0x15 -> rdata 0xFFFFFFAA, resp_valid 2 cycles after handshake, err 0.
REQ-040 Bench SHALL check: LHU addr 0x16 on the same word -> rdata 0x00008899.
REQ-041 Bench SHALL check: SB wdata 0x123 addr 0x17 -> one RD cycle, then one WR cycle with mem_wdata 0x2399AABB, resp_valid at cycle 3.
REQ-042 Bench SHALL check: SW 0xDEADBEEF addr 0x08 -> mem_write with mem_addr 2 at cycle 1, resp_valid at cycle 2, with no read.
REQ-043 Bench SHALL check: LW addr 0x0A -> with the macro, err=1 at cycle 1 and no mem_read; without it, the word at index 2 is returned.
REQ-044 Bench SHALL check: rst asserted during the RD of an SH -> mem_write stays 0, state IDLE, req_ready 1 on the next cycle; funct3=3 load -> err=1.
